clock_divider: RTL and testbench
================================

CLOCK_DIVIDER -- requirements
Module: clock_divider

Interface
REQ-001 Parameter CNT_WIDTH, default 26: width of the half-period counter and of every divisor value.
REQ-002 Parameter DIV_DEF, default 25: half-period terminal count for freq=000; also the reset value of the programmable divisor.
REQ-003 Parameter DIV_SLOW, default 25000000: terminal count for freq=001.
REQ-004 Parameter DIV_MED, default 25000: terminal count for freq=010.
REQ-005 Parameter DIV_FAST, default 0: terminal count for freq=011.
REQ-006 clk  input  1  system clock; all logic on its rising edge.
REQ-007 reset  input  1  reset, synchronous, active-high.
REQ-008 halt  input  1  request to park the output clock.
REQ-009 step  input  1  single-cycle pulse requesting one output period while parked.
REQ-010 freq  input  3  divisor select: 000 DIV_DEF, 001 DIV_SLOW, 010 DIV_MED, 011 DIV_FAST, 1xx programmable register.
REQ-011 div_load  input  1  writes div_value into the programmable divisor register.
REQ-012 div_value  input  CNT_WIDTH  programmable terminal count.
REQ-013 clk_out  output  1  divided clock, registered.
REQ-014 rise_tick  output  1  high for the single clk cycle in which clk_out is 1 and was 0 on the previous cycle.
REQ-015 fall_tick  output  1  high for the single clk cycle in which clk_out is 0 and was 1 on the previous cycle.
REQ-016 parked  output  1  high while the generator is stopped in PARK.

Function
REQ-017 The counter increments each cycle while running; when count equals the active terminal count N, count returns to 0 and clk_out toggles on the same edge, giving a half-period of N+1 clk cycles.
REQ-018 The active N is latched from the freq/programmable selection only on a toggle edge and at reset; freq or div_load changes mid-half-period never shorten or stretch the current half-period.
REQ-019 N=0 toggles clk_out every cycle (output period = 2 clk cycles).
REQ-020 The programmable register updates on the cycle after div_load; a freq=1xx selection takes effect at the next toggle.
REQ-021 The FSM has states RUN, PARK and STEP.
REQ-022 RUN -> PARK when halt=1 at a toggle that drives clk_out 0->1; a low phase in progress always completes first, so parking occurs only with clk_out=1.
REQ-023 If halt=1 while clk_out=1 in RUN, the current high phase continues; the next toggle (1->0) is suppressed, and the FSM enters PARK with count=0.
REQ-024 PARK holds clk_out=1 and count=0; parked=1.
REQ-025 PARK -> RUN when halt=0; counting resumes from 0 on the following cycle with clk_out=1.
REQ-026 PARK -> STEP on step=1 while halt=1; STEP emits one low phase and one high phase, each N+1 cycles long, then returns to PARK.
REQ-027 step is ignored in RUN and STEP; a halt deassertion during STEP completes the step, then enters RUN without re-entering PARK.
REQ-028 When halt and step are both asserted in the cycle PARK is entered, step is ignored.
REQ-029 The counter is exactly CNT_WIDTH bits; no wrap is possible because N < 2^CNT_WIDTH.

Reset
REQ-030 reset has priority over all inputs.
REQ-031 On reset: count=0, clk_out=0, rise_tick=0, fall_tick=0, parked=0, state=RUN, programmable register=DIV_DEF, active N latched from the current freq.
REQ-032 Reset asserted during STEP or PARK aborts it; the FSM resumes in RUN after reset.

Structure
REQ-033 A shared package holds the freq encodings, the FSM state encoding and the default divisor constants.
REQ-034 A sub-module, div_counter, holds the counter, terminal compare and N latch; the FSM and tick logic stay at top level.

Verification
REQ-035 Run with CNT_WIDTH=8, DIV_DEF=3 and freq=000 after reset -> clk_out rises at cycle 4 and falls at cycle 8, with one rise_tick or fall_tick at each edge.
REQ-036 freq=011 -> clk_out toggles every cycle; switching to 000 mid-high phase -> the current phase is 1 cycle, then half-phases are 4 cycles.
REQ-037 Load div_value=9, then select freq=100 -> half-periods of 10 cycles begin at the next toggle.
REQ-038 Assert halt mid-low phase -> the low phase completes, clk_out rises and stays 1, parked=1, no fall_tick occurs.
REQ-039 While parked, pulse step with N=3 -> exactly one fall_tick, then one rise_tick 4 cycles later, then PARK again; a second step pulse issued during STEP has no effect.
REQ-040 Assert reset during STEP -> next cycle clk_out=0, parked=0, state=RUN, count=0.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// Shared constants for the clock divider: divisor-select encodings,
// FSM state encoding and default divisor values.
package clock_divider_pkg;

  localparam logic [2:0] FREQ_DEF  = 3'b000;
  localparam logic [2:0] FREQ_SLOW = 3'b001;
  localparam logic [2:0] FREQ_MED  = 3'b010;
  localparam logic [2:0] FREQ_FAST = 3'b011;

  localparam int unsigned CNT_WIDTH_DFLT = 26;
  localparam int unsigned DIV_DEF_DFLT   = 25;
  localparam int unsigned DIV_SLOW_DFLT  = 25_000_000;
  localparam int unsigned DIV_MED_DFLT   = 25_000;
  localparam int unsigned DIV_FAST_DFLT  = 0;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PARK = 2'd1,
    ST_STEP = 2'd2
  } state_e;

endpackage

// File: rtl/clock_divider_div_counter.sv
// Half-period counter with terminal compare; the active terminal count is
// captured only at reset and at each terminal count so a phase never changes length.
module div_counter #(
  parameter int unsigned CNT_WIDTH = 26
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold_i,
  input  logic [CNT_WIDTH-1:0] n_sel_i,
  output logic                 tc_o
);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] n_q;

  assign tc_o = (count_q == n_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      n_q     <= n_sel_i;
    end else if (hold_i) begin
      count_q <= '0;
    end else if (tc_o) begin
      count_q <= '0;
      n_q     <= n_sel_i;
    end else begin
      count_q <= count_q + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/clock_divider.sv
// Programmable clock divider with halt/park and single-step of one output period.
// The FSM and edge ticks live here; counting and divisor latching live in div_counter.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DFLT,
  parameter int unsigned DIV_DEF   = DIV_DEF_DFLT,
  parameter int unsigned DIV_SLOW  = DIV_SLOW_DFLT,
  parameter int unsigned DIV_MED   = DIV_MED_DFLT,
  parameter int unsigned DIV_FAST  = DIV_FAST_DFLT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 halt,
  input  logic                 step,
  input  logic [2:0]           freq,
  input  logic                 div_load,
  input  logic [CNT_WIDTH-1:0] div_value,
  output logic                 clk_out,
  output logic                 rise_tick,
  output logic                 fall_tick,
  output logic                 parked
);

  state_e               state_q;
  logic                 clk_out_q;
  logic                 rise_q;
  logic                 fall_q;
  logic                 parked_q;
  logic [CNT_WIDTH-1:0] prog_q;
  logic [CNT_WIDTH-1:0] n_sel_d;
  logic                 tc;

  always_ff @(posedge clk) begin
    if (reset) begin
      prog_q <= CNT_WIDTH'(DIV_DEF);
    end else if (div_load) begin
      prog_q <= div_value;
    end
  end

  // During reset the programmable register is itself being reset, so a 1xx
  // selection must latch the reset value rather than the old register contents.
  always_comb begin
    n_sel_d = prog_q;
    case (freq)
      FREQ_DEF:  n_sel_d = CNT_WIDTH'(DIV_DEF);
      FREQ_SLOW: n_sel_d = CNT_WIDTH'(DIV_SLOW);
      FREQ_MED:  n_sel_d = CNT_WIDTH'(DIV_MED);
      FREQ_FAST: n_sel_d = CNT_WIDTH'(DIV_FAST);
      default:   n_sel_d = reset ? CNT_WIDTH'(DIV_DEF) : prog_q;
    endcase
  end

  div_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_div_counter (
    .clk    (clk),
    .reset  (reset),
    .hold_i (state_q == ST_PARK),
    .n_sel_i(n_sel_d),
    .tc_o   (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      clk_out_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      parked_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (tc) begin
            if (halt) begin
              // Park only with clk_out high: finish a low phase with a rise,
              // or swallow the falling toggle of a high phase.
              if (!clk_out_q) begin
                clk_out_q <= 1'b1;
                rise_q    <= 1'b1;
              end
              state_q  <= ST_PARK;
              parked_q <= 1'b1;
            end else begin
              clk_out_q <= ~clk_out_q;
              rise_q    <= ~clk_out_q;
              fall_q    <= clk_out_q;
            end
          end
        end
        ST_PARK: begin
          if (!halt) begin
            state_q  <= ST_RUN;
            parked_q <= 1'b0;
          end else if (step) begin
            state_q   <= ST_STEP;
            parked_q  <= 1'b0;
            clk_out_q <= 1'b0;
            fall_q    <= 1'b1;
          end
        end
        ST_STEP: begin
          if (tc) begin
            if (!clk_out_q) begin
              clk_out_q <= 1'b1;
              rise_q    <= 1'b1;
            end else if (halt) begin
              state_q  <= ST_PARK;
              parked_q <= 1'b1;
            end else begin
              state_q   <= ST_RUN;
              clk_out_q <= 1'b0;
              fall_q    <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign clk_out   = clk_out_q;
  assign rise_tick = rise_q;
  assign fall_tick = fall_q;
  assign parked    = parked_q;

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider: expected output edges are queued with
// their cycle numbers and matched against rise_tick/fall_tick as they appear.
module tb_clock_divider;

  logic       clk;
  logic       reset;
  logic       halt;
  logic       step;
  logic [2:0] freq;
  logic       div_load;
  logic [7:0] div_value;
  logic       clk_out;
  logic       rise_tick;
  logic       fall_tick;
  logic       parked;

  typedef struct {
    bit rise;
    int cyc;
  } ev_t;

  ev_t sb_q[$];
  int  cyc;
  int  checks;
  int  fails;

  clock_divider #(
    .CNT_WIDTH(8),
    .DIV_DEF  (3),
    .DIV_SLOW (20),
    .DIV_MED  (6),
    .DIV_FAST (0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .halt     (halt),
    .step     (step),
    .freq     (freq),
    .div_load (div_load),
    .div_value(div_value),
    .clk_out  (clk_out),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick),
    .parked   (parked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_edge(input bit rise, input int c);
    ev_t e;
    e.rise = rise;
    e.cyc  = c;
    sb_q.push_back(e);
  endtask

  // Advance one clock, sample 1 time unit later and retire scoreboard entries.
  task automatic cycle();
    ev_t e;
    @(posedge clk);
    cyc++;
    #1;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
      e = sb_q.pop_front();
      checks++;
      fails++;
      $display("FAIL missed_edge: got no tick, expected rise=%0b at cycle %0d", e.rise, e.cyc);
    end
    if (rise_tick || fall_tick) begin
      checks++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_edge: got rise=%0b fall=%0b at cycle %0d, expected none",
                 rise_tick, fall_tick, cyc);
      end else begin
        e = sb_q.pop_front();
        if (e.cyc != cyc || rise_tick !== e.rise || fall_tick !== !e.rise || clk_out !== e.rise) begin
          fails++;
          $display("FAIL edge_match: got rise=%0b fall=%0b clk_out=%0b at cycle %0d, expected rise=%0b at cycle %0d",
                   rise_tick, fall_tick, clk_out, cyc, e.rise, e.cyc);
        end
      end
    end
  endtask

  task automatic drain_check(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL %s_pending: got %0d edges outstanding, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic do_reset(input logic [2:0] f, output int r);
    freq     = f;
    halt     = 1'b0;
    step     = 1'b0;
    div_load = 1'b0;
    reset    = 1'b1;
    cycle();
    reset    = 1'b0;
    r        = cyc;
  endtask

  task automatic test_reset();
    int  r;
    logic exp_clk;
    reset = 1'b1; halt = 1'b0; step = 1'b0; freq = 3'b000;
    div_load = 1'b0; div_value = 8'd0;
    cycle();
    cycle();
    checks++;
    if (clk_out !== 1'b0 || rise_tick !== 1'b0 || fall_tick !== 1'b0 || parked !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got clk_out=%0b rise=%0b fall=%0b parked=%0b, expected all 0",
               clk_out, rise_tick, fall_tick, parked);
    end
    r = cyc;
    reset = 1'b0;
    expect_edge(1'b1, r + 4);
    expect_edge(1'b0, r + 8);
    expect_edge(1'b1, r + 12);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      exp_clk = ((k / 4) % 2) == 1;
      checks++;
      if (clk_out !== exp_clk) begin
        fails++;
        $display("FAIL div_def_level: got clk_out=%0b, expected %0b at k=%0d", clk_out, exp_clk, k);
      end
    end
    drain_check("reset");
  endtask

  task automatic test_fast_switch();
    int r;
    do_reset(3'b011, r);
    expect_edge(1'b1, r + 1);
    expect_edge(1'b0, r + 2);
    expect_edge(1'b1, r + 3);
    expect_edge(1'b0, r + 4);
    expect_edge(1'b1, r + 8);
    expect_edge(1'b0, r + 12);
    for (int k = 1; k <= 13; k++) begin
      cycle();
      if (k == 3) freq = 3'b000;
    end
    drain_check("fast_switch");
  endtask

  task automatic test_prog();
    int r;
    do_reset(3'b000, r);
    div_load  = 1'b1;
    div_value = 8'd9;
    expect_edge(1'b1, r + 4);
    expect_edge(1'b0, r + 14);
    expect_edge(1'b1, r + 24);
    expect_edge(1'b0, r + 27);
    expect_edge(1'b1, r + 30);
    for (int k = 1; k <= 31; k++) begin
      cycle();
      if (k == 1) begin
        div_load = 1'b0;
        freq     = 3'b100;
      end
      if (k == 15) begin
        div_load  = 1'b1;
        div_value = 8'd2;
      end
      if (k == 16) div_load = 1'b0;
    end
    drain_check("prog");
  endtask

  task automatic test_halt();
    int   r;
    logic exp_clk;
    logic exp_park;
    do_reset(3'b000, r);
    expect_edge(1'b1, r + 4);
    expect_edge(1'b0, r + 25);
    expect_edge(1'b1, r + 29);
    for (int k = 1; k <= 30; k++) begin
      cycle();
      exp_park = (k >= 4 && k <= 20);
      exp_clk  = (k >= 4 && k < 25) || (k >= 29);
      checks++;
      if (parked !== exp_park || clk_out !== exp_clk) begin
        fails++;
        $display("FAIL halt_park: got parked=%0b clk_out=%0b, expected parked=%0b clk_out=%0b at k=%0d",
                 parked, clk_out, exp_park, exp_clk, k);
      end
      if (k == 1)  halt = 1'b1;
      if (k == 3)  step = 1'b1;
      if (k == 4)  step = 1'b0;
      if (k == 20) halt = 1'b0;
    end
    drain_check("halt");
  endtask

  task automatic test_step();
    int   r;
    logic exp_park;
    do_reset(3'b000, r);
    expect_edge(1'b1, r + 4);
    expect_edge(1'b0, r + 13);
    expect_edge(1'b1, r + 17);
    expect_edge(1'b0, r + 23);
    expect_edge(1'b1, r + 27);
    expect_edge(1'b0, r + 31);
    expect_edge(1'b1, r + 35);
    for (int k = 1; k <= 36; k++) begin
      cycle();
      exp_park = (k >= 8 && k <= 12) || (k >= 21 && k <= 22);
      checks++;
      if (parked !== exp_park) begin
        fails++;
        $display("FAIL step_parked: got parked=%0b, expected %0b at k=%0d", parked, exp_park, k);
      end
      case (k)
        5:  halt = 1'b1;
        12: step = 1'b1;
        13: step = 1'b0;
        14: step = 1'b1;
        15: step = 1'b0;
        22: step = 1'b1;
        23: step = 1'b0;
        28: halt = 1'b0;
        default: ;
      endcase
    end
    drain_check("step");
  endtask

  task automatic test_reset_in_step();
    int r;
    do_reset(3'b000, r);
    halt = 1'b1;
    expect_edge(1'b1, r + 4);
    expect_edge(1'b0, r + 6);
    expect_edge(1'b1, r + 12);
    expect_edge(1'b0, r + 16);
    expect_edge(1'b1, r + 20);
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (k == 5) begin
        checks++;
        if (parked !== 1'b1) begin
          fails++;
          $display("FAIL pre_step_parked: got parked=%0b, expected 1", parked);
        end
        step = 1'b1;
      end
      if (k == 6) step = 1'b0;
      if (k == 7) begin
        reset = 1'b1;
        halt  = 1'b0;
      end
      if (k == 8) begin
        checks++;
        if (clk_out !== 1'b0 || parked !== 1'b0 || rise_tick !== 1'b0 || fall_tick !== 1'b0) begin
          fails++;
          $display("FAIL reset_in_step: got clk_out=%0b parked=%0b rise=%0b fall=%0b, expected all 0",
                   clk_out, parked, rise_tick, fall_tick);
        end
        reset = 1'b0;
      end
    end
    drain_check("reset_in_step");
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    fails  = 0;
    test_reset();
    test_fast_switch();
    test_prog();
    test_halt();
    test_step();
    test_reset_in_step();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
